// File: rtl/button_conditioner.sv
// Nine-button conditioner: 2-FF sync, counter debounce and rising-edge one-shot per button.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the four direction buttons [3:0].
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 7500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn_raw,
  input  logic       game_over,
  output logic       move_left,
  output logic       move_right,
  output logic       move_up,
  output logic       move_down,
  output logic       rotate_block,
  output logic       place_block,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic [8:0] btn_level
);

  localparam int NB       = 9;
  localparam int NDIR     = 4;
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    pulse;
  logic [NB-1:0]    accept;
  logic [NB-1:0]    press;
  logic [NDIR-1:0]  rep_fire;
  logic [CNT_W-1:0] cnt [NB];

  // accept: s2 has disagreed with stable for DEBOUNCE_CYCLES consecutive edges
  always_comb begin
    accept = '0;
    for (int i = 0; i < NB; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
    press = accept & s2;
  end

  // Stage boundary: synchroniser, debounce counters, stable level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic [RCNT_W-1:0] rcnt [NDIR];
  logic [NDIR-1:0]   rphase;

  // rphase=0 waits out the initial delay, rphase=1 paces subsequent repeats
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NDIR; i++) begin
      rep_fire[i] = stable[i] && !accept[i] &&
                    (rcnt[i] == (rphase[i] ? RATE_LAST : DELAY_LAST));
    end
  end

  // Stage boundary: repeat timers
  always_ff @(posedge clk) begin
    if (reset) begin
      rphase <= '0;
      for (int i = 0; i < NDIR; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        if (press[i] || !stable[i] || accept[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign rep_fire      = '0;
`endif

  // Stage boundary: registered one-shot, high in the cycle stable first reads 1
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= '0;
    end else begin
      pulse <= press | {{(NB-NDIR){1'b0}}, rep_fire};
    end
  end

  assign move_left    = pulse[0] & ~game_over;
  assign move_right   = pulse[1] & ~game_over;
  assign move_up      = pulse[2] & ~game_over;
  assign move_down    = pulse[3] & ~game_over;
  assign rotate_block = pulse[4] & ~game_over;
  assign place_block  = pulse[5] & ~game_over;
  assign sel1         = pulse[6] & ~game_over;
  assign sel2         = pulse[7] & ~game_over;
  assign sel3         = pulse[8] & ~game_over;
  assign btn_level    = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued by cycle and checked every cycle.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] btn_raw;
  logic       game_over;
  logic       move_left, move_right, move_up, move_down;
  logic       rotate_block, place_block, sel1, sel2, sel3;
  logic [8:0] btn_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .game_over   (game_over),
    .move_left   (move_left),
    .move_right  (move_right),
    .move_up     (move_up),
    .move_down   (move_down),
    .rotate_block(rotate_block),
    .place_block (place_block),
    .sel1        (sel1),
    .sel2        (sel2),
    .sel3        (sel3),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] mask;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic [8:0] pulses;
  assign pulses = {sel3, sel2, sel1, place_block, rotate_block,
                   move_down, move_up, move_right, move_left};

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle the pulse vector must match the queued entry for that cycle, else all zero
  always @(negedge clk) begin
    logic [8:0] expv;
    if (mon_en) begin
      expv = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        expv = q[0].mask;
        void'(q.pop_front());
      end
      checks++;
      assert (pulses === expv) else begin
        errors++;
        $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, pulses, expv);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Press sampled first at edge c0+1, held for `hold` edges; pulse at c0+DB+2.
  // Stable stays 1 through edge c0+hold+DB+1, so repeats fire only before then.
  task automatic push_press(input int c0, input logic [8:0] mask, input int hold);
    exp_t e;
    e.cyc  = c0 + DB + 2;
    e.mask = mask;
    q.push_back(e);
`ifdef AUTO_REPEAT_EN
    if ((mask & 9'h1F0) == '0) begin
      for (int t = c0 + DB + 2 + RD; t < c0 + hold + DB + 2; t += RR) begin
        e.cyc = t;
        q.push_back(e);
      end
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    reset     = 1'b1;
    btn_raw   = '0;
    game_over = 1'b0;
    tick(3);
    chk("reset_pulses", pulses, 9'h000);
    chk("reset_level", btn_level, 9'h000);
    mon_en = 1'b1;
    reset  = 1'b0;
    tick(3);

    // 1: left press, pulse and level at cycle 6
    c = cyc;
    btn_raw[0] = 1'b1;
    push_press(c, 9'h001, 20);
    tick(DB + 1);
    chk("left_level_before", btn_level, 9'h000);
    tick(1);
    chk("left_level_after", btn_level, 9'h001);
    tick(14);
    btn_raw[0] = 1'b0;
    tick(DB + 6);
    chk("left_released", btn_level, 9'h000);

    // 2: bouncy place button never accepted
    for (int k = 0; k < 5; k++) begin
      btn_raw[5] = 1'b1;
      tick(3);
      btn_raw[5] = 1'b0;
      tick(1);
      chk("place_bounce_level", btn_level, 9'h000);
    end
    tick(8);
    chk("place_bounce_final", btn_level, 9'h000);

    // 3: simultaneous rotate and sel1
    c = cyc;
    btn_raw[4] = 1'b1;
    btn_raw[6] = 1'b1;
    push_press(c, 9'h050, 10);
    tick(DB + 2);
    chk("simul_level", btn_level, 9'h050);
    tick(4);
    btn_raw[4] = 1'b0;
    btn_raw[6] = 1'b0;
    tick(DB + 6);
    chk("simul_released", btn_level, 9'h000);

    // 4: game_over suppresses the right pulse, level still follows
    game_over  = 1'b1;
    btn_raw[1] = 1'b1;
    tick(DB + 4);
    chk("gameover_level", btn_level, 9'h002);
    chk("gameover_right", {8'h00, move_right}, 9'h000);
    game_over = 1'b0;
    tick(5);
    btn_raw[1] = 1'b0;
    tick(DB + 6);
    chk("gameover_released", btn_level, 9'h000);

    // 5: reset in mid-debounce with up held; pulse 6 cycles after release of reset
    c = cyc;
    btn_raw[2] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("midreset_pulses", pulses, 9'h000);
    chk("midreset_level", btn_level, 9'h000);
    reset = 1'b0;
    push_press(c + 5, 9'h004, 15);
    tick(DB + 2);
    chk("midreset_level_after", btn_level, 9'h004);
    tick(9);
    btn_raw[2] = 1'b0;
    tick(DB + 6);
    chk("midreset_released", btn_level, 9'h000);

    // 6: down held 30 cycles (repeats only with AUTO_REPEAT_EN)
    c = cyc;
    btn_raw[3] = 1'b1;
    push_press(c, 9'h008, 30);
    tick(30);
    chk("down_level_held", btn_level, 9'h008);
    btn_raw[3] = 1'b0;
    tick(DB + 8);
    chk("down_released", btn_level, 9'h000);

    tick(5);
    chk("queue_drained", 9'(q.size()), 9'h000);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
